// File: rtl/dram_pkg.sv
// dram_pkg: shared encodings for the data-memory access sequencer.
//   - mem_we store-size codes and mem_rsel load-type codes
//   - mem_err completion codes
//   - FSM state enum
//   - is_misaligned(): alignment rule shared by the controller
package dram_pkg;

  localparam logic [1:0] WE_LOAD = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  localparam logic [2:0] RSEL_LB  = 3'b000;
  localparam logic [2:0] RSEL_LBU = 3'b001;
  localparam logic [2:0] RSEL_LH  = 3'b010;
  localparam logic [2:0] RSEL_LHU = 3'b011;
  localparam logic [2:0] RSEL_LW  = 3'b100;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  // Halves must sit on an even byte, words on a multiple of four. Loads take
  // their size from rsel (1xx is a word), stores from we.
  function automatic logic is_misaligned(input logic [1:0] we,
                                         input logic [2:0] rsel,
                                         input logic [1:0] lane);
    logic half;
    logic full;
    if (we == WE_LOAD) begin
      half = (rsel[2:1] == 2'b01);
      full = rsel[2];
    end else begin
      half = (we == WE_HALF);
      full = (we == WE_WORD);
    end
    return (half && lane[0]) || (full && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/dram_access_ctrl_if.sv
// dram_access_ctrl_if: word-wide data-memory bus, one beat at a time.
//   bus_req   master->slave  beat request, held until ack or abandon
//   bus_we    master->slave  beat is a write
//   bus_addr  master->slave  word-aligned byte address
//   bus_wdata master->slave  full write word
//   bus_ack   slave->master  one-cycle beat completion
//   bus_rdata slave->master  read word, valid with bus_ack
interface dram_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dram_lane_mux.sv
// dram_lane_mux: combinational byte/half lane handling.
//   word         in  32  word read from the bus
//   data         in  32  store data (low bits used for sub-word stores)
//   lane         in  2   byte address bits [1:0]
//   rsel         in  3   load type
//   we           in  2   store size
//   load_result  out 32  extracted and extended load value
//   store_result out 32  word with the store data merged into its lane
module dram_lane_mux
  import dram_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [2:0]  rsel,
  input  logic [1:0]  we,
  output logic [31:0] load_result,
  output logic [31:0] store_result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Load path: rsel[2] selects a full word, rsel[1] half vs byte, and
  // rsel[0] zero- instead of sign-extension.
  always_comb begin
    sel_byte = word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    if (rsel[2]) begin
      load_result = word;
    end else if (rsel[1]) begin
      load_result = rsel[0] ? {16'h0000, sel_half} : {{16{sel_half[15]}}, sel_half};
    end else begin
      load_result = rsel[0] ? {24'h000000, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
    end
  end

  // Store path: start from the old word and overwrite only the target lane.
  always_comb begin
    store_result = word;
    case (we)
      WE_BYTE: store_result[{lane, 3'b000} +: 8] = data[7:0];
      WE_HALF: begin
        if (lane[1]) store_result[31:16] = data[15:0];
        else         store_result[15:0]  = data[15:0];
      end
      WE_WORD: store_result = data;
      default: store_result = word;
    endcase
  end

endmodule

// File: rtl/dram_access_ctrl.sv
// dram_access_ctrl: MEM-stage sequencer for a variable-latency data memory.
//   TIMEOUT    param     beat wait limit (>= 2); a beat is abandoned after
//                        TIMEOUT-1 cycles without ack
//   clk, rst   in        clock, async active-high reset
//   mem_req    in  1     access request, held until mem_done
//   mem_we     in  2     store size (00 = load)
//   mem_rsel   in  3     load type
//   mem_addr   in  32    byte address
//   mem_wdata  in  32    store data
//   mem_stall  out 1     mem_req & ~mem_done
//   mem_done   out 1     one-cycle completion pulse
//   mem_rdata  out 32    load result, valid with mem_done
//   mem_err    out 2     completion status, valid with mem_done
//   bus        master    data-memory bus
module dram_access_ctrl
  import dram_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [1:0]  mem_we,
  input  logic [2:0]  mem_rsel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [1:0]  mem_err,
  dram_access_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT);

  state_t        state;
  logic [1:0]    req_we;
  logic [2:0]    req_rsel;
  logic [1:0]    req_lane;
  logic [CW-1:0] beat_cnt;
  logic          beat_expired;
  logic [31:0]   load_word;
  logic [31:0]   merged_word;

  assign mem_stall = mem_req & ~mem_done;

  // The beat gives up on the cycle whose increment would make the counter
  // reach TIMEOUT-1, so bus_req is high for at most TIMEOUT-1 cycles.
  assign beat_expired = (beat_cnt == CW'(TIMEOUT - 2));

  // bus_wdata still holds the raw store data during the RMW read beat, so it
  // doubles as the merge source; the merged word replaces it for the write.
  dram_lane_mux u_lane_mux (
    .word         (bus.bus_rdata),
    .data         (bus.bus_wdata),
    .lane         (req_lane),
    .rsel         (req_rsel),
    .we           (req_we),
    .load_result  (load_word),
    .store_result (merged_word)
  );

  // Sequencer: latches the request in IDLE, runs one or two bus beats, and
  // reports completion through a single DONE cycle. All outputs are
  // registered so bus_req drops immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_we        <= WE_LOAD;
      req_rsel      <= RSEL_LB;
      req_lane      <= 2'b00;
      beat_cnt      <= '0;
      mem_done      <= 1'b0;
      mem_rdata     <= '0;
      mem_err       <= ERR_OK;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            req_we        <= mem_we;
            req_rsel      <= mem_rsel;
            req_lane      <= mem_addr[1:0];
            bus.bus_addr  <= {mem_addr[31:2], 2'b00};
            bus.bus_wdata <= mem_wdata;
            mem_rdata     <= '0;
            mem_err       <= ERR_OK;
            beat_cnt      <= '0;
            if (is_misaligned(mem_we, mem_rsel, mem_addr[1:0])) begin
              state    <= DONE;
              mem_done <= 1'b1;
              mem_err  <= ERR_MISALIGN;
            end else if (mem_we == WE_LOAD) begin
              state       <= RD;
              bus.bus_req <= 1'b1;
              bus.bus_we  <= 1'b0;
            end else if (mem_we == WE_WORD) begin
              state       <= WR;
              bus.bus_req <= 1'b1;
              bus.bus_we  <= 1'b1;
            end else begin
              state       <= RMW_RD;
              bus.bus_req <= 1'b1;
              bus.bus_we  <= 1'b0;
            end
          end
        end
        RD, WR, RMW_RD, RMW_WR: begin
          if (bus.bus_ack) begin
            beat_cnt <= '0;
            if (state == RMW_RD) begin
              bus.bus_wdata <= merged_word;
              bus.bus_we    <= 1'b1;
              state         <= RMW_WR;
            end else begin
              if (state == RD) mem_rdata <= load_word;
              state       <= DONE;
              mem_done    <= 1'b1;
              mem_err     <= ERR_OK;
              bus.bus_req <= 1'b0;
              bus.bus_we  <= 1'b0;
            end
          end else if (beat_expired) begin
            beat_cnt    <= '0;
            state       <= DONE;
            mem_done    <= 1'b1;
            mem_err     <= ERR_TIMEOUT;
            mem_rdata   <= '0;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        DONE: begin
          mem_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
